// File: rtl/hub_port_guard.sv
// rtl/hub_port_guard.sv - per-port jabber and auto-partition gate between MII receivers and the repeater core
module hub_port_guard #(
    parameter int PORT_COUNT      = 4,
    parameter int JABBER_CYCLES   = 10000,
    parameter int UNJAB_CYCLES    = 24,
    parameter int PARTITION_LIMIT = 60,
    parameter int UNPART_CYCLES   = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PORT_COUNT-1:0]   rx_dv,
    input  logic [PORT_COUNT-1:0]   rx_er,
    input  logic [PORT_COUNT*4-1:0] rxd,
    output logic [PORT_COUNT-1:0]   rx_dv_out,
    output logic [PORT_COUNT-1:0]   rx_er_out,
    output logic [PORT_COUNT*4-1:0] rxd_out,
    output logic [PORT_COUNT-1:0]   jabber,
    output logic [PORT_COUNT-1:0]   partition
);

    localparam int LW = $clog2(JABBER_CYCLES + 1);
    localparam int IW = $clog2(UNJAB_CYCLES + 1);
    localparam int CW = $clog2(PARTITION_LIMIT + 1);

    logic [PORT_COUNT-1:0] blocked;
    logic                  primed;

    assign blocked = jabber | partition;

    // No rising edge can be seen on the first cycle after reset, so frames already in flight stay gated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) primed <= 1'b0;
        else        primed <= 1'b1;
    end

    for (genvar i = 0; i < PORT_COUNT; i++) begin : g_port
        logic          dv_prev, col_seen, pass, jab, part;
        logic [LW-1:0] len, len_cur, len_n;
        logic [IW-1:0] idle, idle_inc, idle_n;
        logic [CW-1:0] ccount, cc_inc, cc_n;
        logic          col_n, jab_n, part_n, pass_n;
        logic          frame_start, frame_end, collision;
        logic          dv_o, er_o;
        logic [3:0]    rxd_o;

        assign frame_start = rx_dv[i] & ~dv_prev & primed;
        assign frame_end   = ~rx_dv[i] & dv_prev;
        assign collision   = rx_dv[i] & |(rx_dv & ~blocked & ~(PORT_COUNT'(1) << i));
        assign len_cur     = frame_start ? '0 : len;
        assign idle_inc    = idle + IW'(1);
        assign cc_inc      = (ccount == CW'(PARTITION_LIMIT)) ? ccount : ccount + CW'(1);

        always_comb begin
            len_n  = len;
            idle_n = idle;
            cc_n   = ccount;
            col_n  = frame_start ? 1'b0 : col_seen;
            jab_n  = jab;
            part_n = part;

            if (collision)
                col_n = 1'b1;
            if (rx_dv[i])
                len_n = (len_cur == LW'(JABBER_CYCLES)) ? len_cur : len_cur + LW'(1);

            if (jab) begin
                if (rx_dv[i]) begin
                    idle_n = '0;
                end else if (idle_inc >= IW'(UNJAB_CYCLES)) begin
                    jab_n  = 1'b0;
                    idle_n = '0;
                end else begin
                    idle_n = idle_inc;
                end
            end
            if (rx_dv[i] && (len_cur == LW'(JABBER_CYCLES))) begin
                jab_n  = 1'b1;
                idle_n = '0;
            end

            // Collision history and the length of the frame just ended decide partition state.
            if (frame_end) begin
                if (col_seen) begin
                    cc_n = cc_inc;
                    if (cc_inc == CW'(PARTITION_LIMIT))
                        part_n = 1'b1;
                end else if (part && (32'(len) >= 32'(UNPART_CYCLES))) begin
                    part_n = 1'b0;
                    cc_n   = '0;
                end else if (!part) begin
                    cc_n = '0;
                end
            end

            pass_n = rx_dv[i] & ~jab_n & ~part & (pass | frame_start);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dv_prev  <= 1'b0;
                col_seen <= 1'b0;
                pass     <= 1'b0;
                jab      <= 1'b0;
                part     <= 1'b0;
                len      <= '0;
                idle     <= '0;
                ccount   <= '0;
                dv_o     <= 1'b0;
                er_o     <= 1'b0;
                rxd_o    <= 4'h0;
            end else begin
                dv_prev  <= rx_dv[i];
                col_seen <= col_n;
                pass     <= pass_n;
                jab      <= jab_n;
                part     <= part_n;
                len      <= len_n;
                idle     <= idle_n;
                ccount   <= cc_n;
                dv_o     <= rx_dv[i] & pass_n;
                er_o     <= rx_er[i] & pass_n;
                rxd_o    <= pass_n ? rxd[i*4 +: 4] : 4'h0;
            end
        end

        assign rx_dv_out[i]        = dv_o;
        assign rx_er_out[i]        = er_o;
        assign rxd_out[i*4 +: 4]   = rxd_o;
        assign jabber[i]           = jab;
        assign partition[i]        = part;
    end

endmodule

// File: tb/tb_hub_port_guard.sv
// tb/tb_hub_port_guard.sv - randomized scoreboard bench for hub_port_guard against a behavioural port model
module tb_hub_port_guard;

    localparam int P   = 4;
    localparam int JAB = 16;
    localparam int UNJ = 4;
    localparam int PL  = 3;
    localparam int UNP = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [P-1:0]   rx_dv, rx_er, rx_dv_out, rx_er_out, jabber, partition;
    logic [P*4-1:0] rxd, rxd_out;

    hub_port_guard #(
        .PORT_COUNT(P), .JABBER_CYCLES(JAB), .UNJAB_CYCLES(UNJ),
        .PARTITION_LIMIT(PL), .UNPART_CYCLES(UNP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
        .rx_dv_out(rx_dv_out), .rx_er_out(rx_er_out), .rxd_out(rxd_out),
        .jabber(jabber), .partition(partition)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [P-1:0]   dv, er, jab, part;
        logic [P*4-1:0] d;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ocyc   = 0;
    int   dv2_cnt = 0;
    int   dv3_cnt = 0;

    // Behavioural model: frame length, idle gap and collided-frame streak per port.
    int m_len[P], m_idle[P], m_cc[P];
    bit m_col[P], m_pass[P], m_jab[P], m_part[P], m_prev[P];
    bit m_first;

    task automatic model_reset();
        for (int i = 0; i < P; i++) begin
            m_len[i] = 0; m_idle[i] = 0; m_cc[i] = 0;
            m_col[i] = 0; m_pass[i] = 0; m_jab[i] = 0; m_part[i] = 0; m_prev[i] = 0;
        end
        m_first = 1;
        q.delete();
    endtask

    task automatic model_step();
        bit   blk[P];
        exp_t e;
        e = '{default: '0};
        for (int j = 0; j < P; j++) blk[j] = m_jab[j] || m_part[j];
        for (int i = 0; i < P; i++) begin
            bit dv, start, fin, old_part;
            int others;
            dv       = rx_dv[i];
            start    = dv && !m_prev[i] && !m_first;
            fin      = !dv && m_prev[i];
            old_part = m_part[i];
            others   = 0;
            for (int j = 0; j < P; j++)
                if (j != i && rx_dv[j] && !blk[j]) others++;
            if (start) begin
                m_len[i] = 0;
                m_col[i] = 0;
            end
            if (dv && others > 0) m_col[i] = 1;
            if (m_jab[i]) begin
                if (dv) m_idle[i] = 0;
                else begin
                    m_idle[i]++;
                    if (m_idle[i] >= UNJ) begin
                        m_jab[i]  = 0;
                        m_idle[i] = 0;
                    end
                end
            end
            if (dv && m_len[i] == JAB) begin
                m_jab[i]  = 1;
                m_idle[i] = 0;
            end
            if (dv && m_len[i] < JAB) m_len[i]++;
            if (fin) begin
                if (m_col[i]) begin
                    m_cc[i] = (m_cc[i] + 1 > PL) ? PL : m_cc[i] + 1;
                    if (m_cc[i] == PL) m_part[i] = 1;
                end else if (m_part[i] && m_len[i] >= UNP) begin
                    m_part[i] = 0;
                    m_cc[i]   = 0;
                end else if (!m_part[i]) begin
                    m_cc[i] = 0;
                end
            end
            m_pass[i]      = dv && !m_jab[i] && !old_part && (m_pass[i] || start);
            e.dv[i]        = dv && m_pass[i];
            e.er[i]        = rx_er[i] && m_pass[i];
            e.d[i*4 +: 4]  = m_pass[i] ? rxd[i*4 +: 4] : 4'h0;
            e.jab[i]       = m_jab[i];
            e.part[i]      = m_part[i];
            m_prev[i]      = dv;
        end
        m_first = 0;
        q.push_back(e);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        if (rx_dv_out[2]) dv2_cnt++;
        if (rx_dv_out[3]) dv3_cnt++;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            ocyc++;
            checks++;
            if (rx_dv_out !== e.dv || rx_er_out !== e.er || rxd_out !== e.d ||
                jabber !== e.jab || partition !== e.part) begin
                errors++;
                $display("FAIL out_cycle%0d got/exp dv %b/%b er %b/%b rxd %h/%h jab %b/%b part %b/%b",
                         ocyc, rx_dv_out, e.dv, rx_er_out, e.er, rxd_out, e.d,
                         jabber, e.jab, partition, e.part);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic tick(input logic [P-1:0] dv, input logic [P-1:0] er,
                        input logic [P-1:0] fm, input logic [3:0] fn);
        rx_dv = dv;
        rx_er = er;
        for (int i = 0; i < P; i++)
            rxd[i*4 +: 4] = fm[i] ? fn : 4'($urandom);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick('0, '0, '0, 4'h0);
    endtask

    task automatic burst(input logic [P-1:0] dv, input int n);
        for (int k = 0; k < n; k++) tick(dv, '0, '0, 4'h0);
    endtask

    int           rem[P];
    bit           on[P];
    logic [P-1:0] rdv;

    initial begin
        rx_dv = '0; rx_er = '0; rxd = '0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Reset asserted in the middle of a passing frame on port 0
        burst(4'b0001, 4);
        #2;
        check("pre_reset_dv0", int'(rx_dv_out[0]), 1);
        rst_n = 1'b0;
        #1;
        check("reset_dv_out", int'(rx_dv_out), 0);
        check("reset_er_out", int'(rx_er_out), 0);
        check("reset_rxd_out", int'(rxd_out), 0);
        check("reset_jabber", int'(jabber), 0);
        check("reset_partition", int'(partition), 0);
        @(negedge clk);
        rst_n = 1'b1;
        burst(4'b0001, 5);
        idle(3);
        burst(4'b0001, 4);
        idle(3);

        // Pass-through with one error cycle
        for (int k = 0; k < 10; k++)
            tick(4'b0010, (k == 4) ? 4'b0010 : 4'b0000, 4'b0010, 4'hA);
        idle(3);

        // Jabber on port 2
        dv2_cnt = 0;
        burst(4'b0100, 20);
        idle(2);
        check("jab_passed_cycles", dv2_cnt, JAB);
        check("jab_set", int'(jabber[2]), 1);
        burst(4'b0100, 5);
        check("jab_held", int'(jabber[2]), 1);
        idle(UNJ);
        check("jab_cleared", int'(jabber[2]), 0);
        burst(4'b0100, 3);
        idle(3);

        // Partition through repeated overlap of ports 0 and 3
        for (int f = 0; f < PL; f++) begin
            burst(4'b1001, 6);
            idle(3);
        end
        check("part0_set", int'(partition[0]), 1);
        check("part3_set", int'(partition[3]), 1);
        burst(4'b0001, 5);
        idle(3);
        check("part0_short_frame", int'(partition[0]), 1);
        burst(4'b0001, UNP);
        idle(3);
        check("part0_cleared", int'(partition[0]), 0);
        burst(4'b0001, 4);
        idle(3);

        // Collision streak broken by a clean frame
        burst(4'b0110, 5); idle(3);
        burst(4'b0110, 5); idle(3);
        burst(4'b0010, 5); idle(3);
        burst(4'b0011, 5); idle(3);
        burst(4'b0011, 5); idle(3);
        check("part1_never", int'(partition[1]), 0);

        // Partitioned port 3 releases at the end of a frame that overlaps a jabbering port
        dv3_cnt = 0;
        burst(4'b0100, 18);
        burst(4'b1100, UNP);
        check("part3_mid_frame", int'(partition[3]), 1);
        burst(4'b0100, 2);
        check("part3_released", int'(partition[3]), 0);
        check("part3_blocked_frame", dv3_cnt, 0);
        idle(UNJ + 2);

        // Randomized bursty traffic, with one reset in the middle
        for (int i = 0; i < P; i++) begin
            rem[i] = 0;
            on[i]  = 0;
        end
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) begin
                #2 rst_n = 1'b0;
                #1;
                check("rand_reset_dv_out", int'(rx_dv_out), 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int i = 0; i < P; i++) begin
                if (rem[i] == 0) begin
                    on[i]  = !on[i];
                    rem[i] = on[i] ? int'($urandom_range(1, 22)) : int'($urandom_range(1, 6));
                end
                rem[i]--;
                rdv[i] = on[i];
            end
            tick(rdv, P'($urandom) & P'($urandom) & P'($urandom), '0, 4'h0);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
